spi_tx_word_feeder: RTL and testbench
=====================================

Name: spi_tx_word_feeder

Overview:
- Upstream stage of the SPI slave byte transmitter.
- Accepts fixed-width measurement words from the compressive-sensing datapath over a valid/ready handshake and buffers them in a small FIFO.
- Splits each word into bytes, most-significant byte first, and presents one byte at a time on the transmitter's byte input.
- Advances to the next byte on the transmitter's one-cycle byte-sent pulse; substitutes a fill byte and flags underrun when no data is buffered.

Parameters:
- WORD_W, 16, measurement word width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 8, FIFO depth in words; must be a power of two and at least 2.
- FILL_BYTE, 8'hFF, byte presented while the FIFO is empty.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_word  input  WORD_W  measurement word from the datapath.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  the FIFO can accept a word.
- byte_out  output  8  current byte; drives the transmitter's data input.
- byte_avail  output  1  high while byte_out holds real data; drives the transmitter's enable (signalReceived).
- byte_sent  input  1  one-cycle pulse from the transmitter after 8 bits have shifted out.
- frame_start  input  1  one-cycle pulse at the start of an SPI message (SSEL falling edge, already synchronised).
- underrun  output  1  sticky flag: a byte was sent while the FIFO was empty.
- clear_underrun  input  1  clears underrun.
- level  output  clog2(DEPTH)+1  number of words currently buffered.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; read/write pointers, level and byte index all 0.
  - in_ready=1, byte_avail=0, byte_out=FILL_BYTE, underrun=0.
- Push:
  - Occurs on a clk edge with in_valid=1 and in_ready=1.
  - in_ready = (level != DEPTH), decoded from registered level only.
  - A simultaneous pop does not free a slot for a push in the same cycle.
- Byte index bi, range 0..BYTES-1 where BYTES = WORD_W/8.
  - byte_out = head_word[WORD_W-1-8*bi -: 8] when level > 0; otherwise FILL_BYTE.
  - byte_out and byte_avail are combinational from registered state (FIFO head, bi, level); no extra latency.
  - A word pushed into an empty FIFO appears on byte_out the cycle after the push edge.
- byte_sent pulse with level > 0:
  - If bi < BYTES-1: bi increments.
  - If bi = BYTES-1: bi returns to 0, the head word is popped and level decrements.
  - Push and pop on the same edge: level is unchanged and both pointers advance.
- byte_sent pulse with level = 0:
  - underrun is set; bi and the pointers are unchanged.
- frame_start pulse:
  - bi returns to 0, so the current head word restarts from its MSB byte. No word is discarded.
  - frame_start and byte_sent on the same edge: frame_start wins; no pop, bi=0.
- underrun flag:
  - clear_underrun and an underrun-setting byte_sent on the same edge: underrun stays set (set wins).
- Pointers: DEPTH-sized, wrap modulo DEPTH; level ranges 0..DEPTH.
- byte_sent is treated as a single-cycle pulse. A pulse held for N cycles counts as N events (the transmitter guarantees one cycle).
- Reset asserted mid-word or mid-frame: all buffered data is discarded immediately; the outputs show the reset values above while rst_n=0.

Test Plan:
- Reset, then push 16'hA55A:
  - byte_out=8'hA5 and byte_avail=1 on the next cycle.
  - After byte_sent: byte_out=8'h5A.
  - After a second byte_sent: level=0, byte_out=8'hFF, byte_avail=0.
- Push DEPTH=8 words 16'h0100..16'h0107 back-to-back:
  - in_ready drops after the 8th accept; level=8.
  - A 9th in_valid is held off.
  - Two byte_sent pulses pop one word: level=7, in_ready=1.
- With level=8, apply a push attempt and the final byte_sent of the head word on the same cycle:
  - The push is not accepted; level=7 afterwards.
  - Repeat at level=3: level stays 3 and the pushed word appears in order.
- Push 16'hBEEF, one byte_sent (byte_out=8'hEF), then frame_start:
  - byte_out returns to 8'hBE; level stays 1.
  - frame_start coincident with byte_sent also gives 8'hBE with no pop.
- Empty FIFO, byte_sent:
  - underrun=1, byte_out=8'hFF.
  - clear_underrun together with another byte_sent leaves underrun=1.
  - clear_underrun alone leaves underrun=0.
- Push 3 words, send one byte, assert rst_n=0 for 1 cycle:
  - level=0, byte_avail=0, bi=0.
  - A subsequent push of 16'h1234 presents 8'h12 first.

Source files
------------

// File: rtl/spi_tx_word_feeder.sv
// ---------------------------------------------------------------------------
// spi_tx_word_feeder
//
// Upstream stage of the SPI slave byte transmitter. Measurement words from
// the compressive-sensing datapath are accepted over a valid/ready handshake
// into a small FIFO. The head word is then presented one byte at a time,
// most-significant byte first, on the transmitter's byte input. Each
// byte_sent pulse from the transmitter moves on to the next byte. After the
// last byte of a word has gone out, that word is popped. When nothing is
// buffered, a fill byte is presented instead, and a byte sent in that state
// raises a sticky underrun flag.
//
// Parameters:
//   WORD_W    - measurement word width in bits (multiple of 8, >= 8)
//   DEPTH     - FIFO depth in words (power of two, >= 2)
//   FILL_BYTE - byte presented while the FIFO is empty
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_word        in   measurement word from the datapath
//   in_valid       in   in_word is valid
//   in_ready       out  FIFO can accept a word (level != DEPTH)
//   byte_out       out  current byte to the transmitter
//   byte_avail     out  byte_out holds real data (transmitter enable)
//   byte_sent      in   one-cycle pulse after 8 bits have shifted out
//   frame_start    in   one-cycle pulse at the start of an SPI message
//   underrun       out  sticky: a byte was sent while the FIFO was empty
//   clear_underrun in   clears underrun (a simultaneous set wins)
//   level          out  number of words currently buffered
// ---------------------------------------------------------------------------
module spi_tx_word_feeder #(
  parameter int          WORD_W    = 16,
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_W-1:0]        in_word,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               byte_out,
  output logic                     byte_avail,
  input  logic                     byte_sent,
  input  logic                     frame_start,
  output logic                     underrun,
  input  logic                     clear_underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int BYTES = WORD_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Keep the byte index at least one bit wide so single-byte words still
  // have a legal (constant zero) index register.
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BI_W-1:0]  BI_LAST = BI_W'(BYTES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [BI_W-1:0]   bi;
  logic              underrun_q;

  logic              push_en;
  logic              pop_en;
  logic              has_data;
  logic              bi_last;
  logic [WORD_W-1:0] head_word;
  logic [7:0]        byte_sel;

  // in_ready looks only at the registered level, so a pop on the same edge
  // never opens a slot for a push in that cycle.
  assign in_ready = (level_q != LVL_FULL);
  assign has_data = (level_q != '0);
  assign bi_last  = (bi == BI_LAST);
  assign push_en  = in_valid & in_ready;
  // frame_start rewinds the current word, so it suppresses the pop that a
  // coincident final byte_sent would otherwise cause.
  assign pop_en   = byte_sent & has_data & ~frame_start & bi_last;

  // Storage has no reset; the pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= in_word;
    end
  end

  // Pointers, occupancy, byte index and the sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      bi         <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push_en, pop_en})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      if (frame_start) begin
        bi <= '0;
      end else if (byte_sent && has_data) begin
        bi <= bi_last ? '0 : bi + BI_W'(1);
      end

      // Setting takes priority over clearing so an underrun in the same
      // cycle as a clear request is never lost.
      if (byte_sent && !has_data) begin
        underrun_q <= 1'b1;
      end else if (clear_underrun) begin
        underrun_q <= 1'b0;
      end
    end
  end

  // Select the current byte of the head word, MSB first; fill when empty.
  always_comb begin
    head_word = mem[rd_ptr];
    byte_sel  = FILL_BYTE;
    if (has_data) begin
      for (int k = 0; k < BYTES; k++) begin
        if (bi == BI_W'(k)) begin
          byte_sel = head_word[WORD_W-1-8*k -: 8];
        end
      end
    end
  end

  assign byte_out   = byte_sel;
  assign byte_avail = has_data;
  assign underrun   = underrun_q;
  assign level      = level_q;

endmodule

// File: tb/tb_spi_tx_word_feeder.sv
// ---------------------------------------------------------------------------
// tb_spi_tx_word_feeder
//
// Directed self-checking bench for spi_tx_word_feeder (WORD_W=16, DEPTH=8,
// FILL_BYTE=8'hFF). Each step drives inputs for one clock cycle, starting
// 1 time unit after a rising edge, and outputs are sampled 1 time unit after
// the following rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spi_tx_word_feeder;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic        byte_avail;
  logic        byte_sent;
  logic        frame_start;
  logic        underrun;
  logic        clear_underrun;
  logic [3:0]  level;

  int vectors;
  int miscompares;

  spi_tx_word_feeder #(
    .WORD_W   (16),
    .DEPTH    (8),
    .FILL_BYTE(8'hFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .byte_out      (byte_out),
    .byte_avail    (byte_avail),
    .byte_sent     (byte_sent),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .clear_underrun(clear_underrun),
    .level         (level)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Drive one cycle of inputs, let one rising edge happen, then release the
  // pulse inputs so each call is exactly one cycle of stimulus.
  task automatic applyStimulus(input logic [15:0] word, input logic valid,
                               input logic sent, input logic fstart,
                               input logic clr);
    in_word        = word;
    in_valid       = valid;
    byte_sent      = sent;
    frame_start    = fstart;
    clear_underrun = clr;
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    byte_sent      = 1'b0;
    frame_start    = 1'b0;
    clear_underrun = 1'b0;
  endtask

  task automatic pushWord(input logic [15:0] word);
    applyStimulus(word, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendByte();
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    in_word        = '0;
    in_valid       = 1'b0;
    byte_sent      = 1'b0;
    frame_start    = 1'b0;
    clear_underrun = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",   16'(in_ready),   16'h1);
    checkOutput("rst_byte_avail", 16'(byte_avail), 16'h0);
    checkOutput("rst_byte_out",   16'(byte_out),   16'hFF);
    checkOutput("rst_underrun",   16'(underrun),   16'h0);
    checkOutput("rst_level",      16'(level),      16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, MSB first, then empty.
    pushWord(16'hA55A);
    checkOutput("a55a_msb",   16'(byte_out),   16'hA5);
    checkOutput("a55a_avail", 16'(byte_avail), 16'h1);
    sendByte();
    checkOutput("a55a_lsb",   16'(byte_out),   16'h5A);
    sendByte();
    checkOutput("a55a_level", 16'(level),      16'h0);
    checkOutput("a55a_fill",  16'(byte_out),   16'hFF);
    checkOutput("a55a_avail0",16'(byte_avail), 16'h0);

    // Fill to DEPTH.
    for (int i = 0; i < 8; i++) begin
      pushWord(16'h0100 + 16'(i));
    end
    checkOutput("full_level",    16'(level),    16'h8);
    checkOutput("full_in_ready", 16'(in_ready), 16'h0);
    pushWord(16'h0108);
    checkOutput("full_held_off", 16'(level),    16'h8);
    sendByte();
    checkOutput("full_pop_b1",   16'(byte_out), 16'h00);
    sendByte();
    checkOutput("full_pop_lvl",  16'(level),    16'h7);
    checkOutput("full_pop_rdy",  16'(in_ready), 16'h1);
    checkOutput("full_pop_head", 16'(byte_out), 16'h01);

    // Back to full, then push attempt coincident with the final byte_sent.
    pushWord(16'h0200);
    checkOutput("refull_level", 16'(level), 16'h8);
    sendByte();
    applyStimulus(16'h0300, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("full_push_pop_lvl", 16'(level),    16'h7);
    checkOutput("full_push_pop_hd",  16'(byte_out), 16'h01);

    // Drain to level 3: 0106, 0107, 0200 remain.
    repeat (8) sendByte();
    checkOutput("drain3_level", 16'(level),    16'h3);
    checkOutput("drain3_head",  16'(byte_out), 16'h01);
    sendByte();
    checkOutput("drain3_lsb",   16'(byte_out), 16'h06);
    applyStimulus(16'h0301, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_push_pop_lvl", 16'(level),    16'h3);
    checkOutput("mid_push_pop_hd",  16'(byte_out), 16'h01);
    sendByte();
    checkOutput("order_0107_lsb", 16'(byte_out), 16'h07);
    sendByte();
    checkOutput("order_0200_msb", 16'(byte_out), 16'h02);
    repeat (2) sendByte();
    checkOutput("order_0301_msb", 16'(byte_out), 16'h03);
    sendByte();
    checkOutput("order_0301_lsb", 16'(byte_out), 16'h01);
    sendByte();
    checkOutput("order_empty_lvl",   16'(level),      16'h0);
    checkOutput("order_empty_avail", 16'(byte_avail), 16'h0);

    // frame_start rewinds the head word.
    pushWord(16'hBEEF);
    checkOutput("beef_msb", 16'(byte_out), 16'hBE);
    sendByte();
    checkOutput("beef_lsb", 16'(byte_out), 16'hEF);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("fs_rewind",     16'(byte_out), 16'hBE);
    checkOutput("fs_rewind_lvl", 16'(level),    16'h1);
    sendByte();
    checkOutput("fs_lsb_again",  16'(byte_out), 16'hEF);
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("fs_and_sent",     16'(byte_out), 16'hBE);
    checkOutput("fs_and_sent_lvl", 16'(level),    16'h1);
    repeat (2) sendByte();
    checkOutput("beef_drained", 16'(level), 16'h0);

    // Underrun set, set-wins-over-clear, then clear.
    checkOutput("pre_underrun", 16'(underrun), 16'h0);
    sendByte();
    checkOutput("underrun_set",  16'(underrun), 16'h1);
    checkOutput("underrun_fill", 16'(byte_out), 16'hFF);
    checkOutput("underrun_lvl",  16'(level),    16'h0);
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("underrun_set_wins", 16'(underrun), 16'h1);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("underrun_cleared",  16'(underrun), 16'h0);

    // Reset mid-word discards everything, asynchronously.
    pushWord(16'h1A2B);
    pushWord(16'h3C4D);
    pushWord(16'h5E6F);
    sendByte();
    checkOutput("mid_word_lsb", 16'(byte_out), 16'h2B);
    checkOutput("mid_word_lvl", 16'(level),    16'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_lvl",   16'(level),      16'h0);
    checkOutput("async_rst_avail", 16'(byte_avail), 16'h0);
    checkOutput("async_rst_byte",  16'(byte_out),   16'hFF);
    checkOutput("async_rst_ready", 16'(in_ready),   16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pushWord(16'h1234);
    checkOutput("post_rst_msb", 16'(byte_out), 16'h12);
    checkOutput("post_rst_lvl", 16'(level),    16'h1);
    sendByte();
    checkOutput("post_rst_lsb", 16'(byte_out), 16'h34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
